// File: rtl/uart_wb.sv
// Wishbone slave bridge onto an 8-bit UART register file: one IDLE -> STROBE -> ACK pass per transfer.
// Build option UART_WB_BUS32_EN selects a 32-bit bus with byte lanes; without it the bus is 8 bits wide.
module uart_wb (
    input  logic        clk,
    input  logic        wb_rst_ni,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
`ifdef UART_WB_BUS32_EN
    input  logic [4:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic [31:0] wb_dat_o,
`else
    input  logic [2:0]  wb_adr_i,
    input  logic [7:0]  wb_dat_i,
    output logic [7:0]  wb_dat_o,
`endif
    output logic        wb_ack_o,
    output logic        re_o,
    output logic        we_o,
    output logic [2:0]  adr_o,
    output logic [7:0]  dat8_o,
    input  logic [7:0]  dat8_i
);

`ifdef UART_WB_BUS32_EN
    localparam int DW = 32;
`else
    localparam int DW = 8;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        ACK    = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      adr_q, adr_d;
    logic [7:0]      dat8_q, dat8_d;
    logic            re_q, re_d;
    logic            we_q, we_d;
    logic            ack_q, ack_d;
    logic [DW-1:0]   dat_o_q, dat_o_d;

    logic            req_s;
    logic [2:0]      adr_sel_s;
    logic [7:0]      dat_sel_s;
    logic            lane_s;
    logic [DW-1:0]   rd_word_s;

    assign req_s = wb_cyc_i & wb_stb_i;

`ifdef UART_WB_BUS32_EN
    logic unused_s;
    assign adr_sel_s = wb_adr_i[4:2];
    assign dat_sel_s = wb_dat_i[7:0];
    assign lane_s    = wb_sel_i[0];
    assign rd_word_s = {24'h000000, dat8_i};
    assign unused_s  = ^{wb_adr_i[1:0], wb_dat_i[31:8], wb_sel_i[3:1]};
`else
    assign adr_sel_s = wb_adr_i;
    assign dat_sel_s = wb_dat_i;
    assign lane_s    = 1'b1;
    assign rd_word_s = dat8_i;
`endif

    // Next-state and next-output logic of the transfer sequencer
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dat8_d  = dat8_q;
        re_d    = 1'b0;
        we_d    = 1'b0;
        ack_d   = 1'b0;
        dat_o_d = dat_o_q;
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    state_d = STROBE;
                    adr_d   = adr_sel_s;
                    dat8_d  = dat_sel_s;
                    re_d    = ~wb_we_i;
                    we_d    = wb_we_i & lane_s;
                end else begin
                    state_d = IDLE;
                end
            end
            STROBE: begin
                state_d = ACK;
                // A master that dropped its cycle here gets no ack, but the strobe still finishes.
                ack_d   = req_s;
                if (re_q) begin
                    dat_o_d = rd_word_s;
                end else begin
                    dat_o_d = dat_o_q;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by the bus reset
    always_ff @(posedge clk or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            adr_q   <= 3'd0;
            dat8_q  <= 8'd0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            ack_q   <= 1'b0;
            dat_o_q <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat8_q  <= dat8_d;
            re_q    <= re_d;
            we_q    <= we_d;
            ack_q   <= ack_d;
            dat_o_q <= dat_o_d;
        end
    end

    // Ack is also qualified by the live request so a cycle aborted during ACK sees no ack.
    assign wb_ack_o = ack_q & req_s;
    assign re_o     = re_q;
    assign we_o     = we_q;
    assign adr_o    = adr_q;
    assign dat8_o   = dat8_q;
    assign wb_dat_o = dat_o_q;

endmodule

// File: tb/tb_uart_wb.sv
// Self-checking bench for uart_wb: directed spec scenarios plus randomized transfers against a
// transaction-level model of the register file and read-data holding register.
module tb_uart_wb;

`ifdef UART_WB_BUS32_EN
    localparam int AW = 5;
    localparam int DW = 32;
`else
    localparam int AW = 3;
    localparam int DW = 8;
`endif

    logic          clk = 1'b0;
    logic          wb_rst_ni;
    logic          cyc, stb, we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat_i;
    logic [3:0]    sel;
    logic [DW-1:0] dat_o;
    logic          ack, re_o, we_o;
    logic [2:0]    adr_o;
    logic [7:0]    dat8_o;
    logic [7:0]    dat8_i;

    int tests_run    = 0;
    int tests_failed = 0;

    // Register file seen by the bridge, and the bench's model of it.
    logic [7:0] rf       [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h60, 8'h77, 8'h88};
    logic [7:0] model_rf [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h60, 8'h77, 8'h88};
    logic [DW-1:0] model_dato;

    uart_wb dut (
        .clk       (clk),
        .wb_rst_ni (wb_rst_ni),
        .wb_cyc_i  (cyc),
        .wb_stb_i  (stb),
        .wb_we_i   (we),
        .wb_adr_i  (adr),
        .wb_dat_i  (dat_i),
`ifdef UART_WB_BUS32_EN
        .wb_sel_i  (sel),
`endif
        .wb_dat_o  (dat_o),
        .wb_ack_o  (ack),
        .re_o      (re_o),
        .we_o      (we_o),
        .adr_o     (adr_o),
        .dat8_o    (dat8_o),
        .dat8_i    (dat8_i)
    );

    always #5 clk = ~clk;

    assign dat8_i = rf[adr_o];

    always @(posedge clk) begin
        if (we_o) rf[adr_o] <= dat8_o;
    end

    always @(negedge clk) begin
        if (wb_rst_ni === 1'b1) begin
            tests_run++;
            if ((re_o & we_o) !== 1'b0) begin
                tests_failed++;
                $display("FAIL excl_strobe: re_o=%b we_o=%b required not both 1", re_o, we_o);
            end
        end
    end

    function automatic logic [AW-1:0] mk_adr(input logic [2:0] idx);
`ifdef UART_WB_BUS32_EN
        logic [1:0] lo;
        lo = 2'($urandom);
        return {idx, lo};
`else
        return idx;
`endif
    endfunction

    function automatic logic [DW-1:0] mk_dat(input logic [7:0] b);
`ifdef UART_WB_BUS32_EN
        logic [23:0] hi;
        hi = 24'($urandom);
        return {hi, b};
`else
        return b;
`endif
    endfunction

    function automatic bit lane_on(input logic [3:0] s);
`ifdef UART_WB_BUS32_EN
        return s[0];
`else
        return 1'b1;
`endif
    endfunction

    task automatic do_xfer(input bit wr, input logic [2:0] idx, input logic [7:0] b,
                           input logic [3:0] s, input bit abort, input string tag);
        bit exp_we;
        bit exp_re;
        exp_we = wr && lane_on(s);
        exp_re = !wr;
        cyc = 1'b1; stb = 1'b1; we = wr; adr = mk_adr(idx); dat_i = mk_dat(b); sel = s;
        @(posedge clk); #1;
        tests_run += 6;
        if (re_o !== exp_re) begin tests_failed++; $display("FAIL %s re_strobe: got %b need %b", tag, re_o, exp_re); end
        if (we_o !== exp_we) begin tests_failed++; $display("FAIL %s we_strobe: got %b need %b", tag, we_o, exp_we); end
        if (adr_o !== idx) begin tests_failed++; $display("FAIL %s adr_o: got %0d need %0d", tag, adr_o, idx); end
        if (dat8_o !== b) begin tests_failed++; $display("FAIL %s dat8_o: got %02h need %02h", tag, dat8_o, b); end
        if (ack !== 1'b0) begin tests_failed++; $display("FAIL %s early_ack: got %b need 0", tag, ack); end
        if (dat_o !== model_dato) begin tests_failed++; $display("FAIL %s dat_o_hold: got %0h need %0h", tag, dat_o, model_dato); end
        if (abort) begin cyc = 1'b0; stb = 1'b0; end
        @(posedge clk); #1;
        if (!wr) model_dato = DW'(model_rf[idx]);
        if (exp_we) model_rf[idx] = b;
        tests_run += 4;
        if ((re_o | we_o) !== 1'b0) begin tests_failed++; $display("FAIL %s strobe_len: got re=%b we=%b need 0", tag, re_o, we_o); end
        if (ack !== !abort) begin tests_failed++; $display("FAIL %s ack: got %b need %b", tag, ack, !abort); end
        if (dat_o !== model_dato) begin tests_failed++; $display("FAIL %s dat_o: got %0h need %0h", tag, dat_o, model_dato); end
        if (rf[idx] !== model_rf[idx]) begin tests_failed++; $display("FAIL %s rf_write: got %02h need %02h", tag, rf[idx], model_rf[idx]); end
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if ({ack, re_o, we_o} !== 3'b000) begin tests_failed++; $display("FAIL %s idle_quiet: got %b need 000", tag, {ack, re_o, we_o}); end
    endtask

    task automatic test_reset();
        wb_rst_ni = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_i = '0; sel = 4'h0;
        model_dato = '0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({ack, re_o, we_o, adr_o, dat8_o} !== 14'd0 || dat_o !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: got ack=%b re=%b we=%b adr=%0d d8=%02h dat_o=%0h need all 0",
                     ack, re_o, we_o, adr_o, dat8_o, dat_o);
        end
        @(negedge clk);
        wb_rst_ni = 1'b1;
        do_xfer(1'b0, 3'd2, 8'h5a, 4'h0, 1'b0, "first_after_reset");
    endtask

    task automatic test_directed();
        do_xfer(1'b1, 3'd3, 8'h83, 4'b0001, 1'b0, "write_83");
        do_xfer(1'b0, 3'd5, 8'h00, 4'b0000, 1'b0, "read_60");
        tests_run++;
        if (model_dato !== DW'(8'h60)) begin tests_failed++; $display("FAIL read_60_value: got %0h need 60", model_dato); end
        do_xfer(1'b0, 3'd3, 8'h00, 4'b0000, 1'b0, "readback_83");
    endtask

    task automatic test_sel_lane();
`ifdef UART_WB_BUS32_EN
        do_xfer(1'b1, 3'd3, 8'h55, 4'b1110, 1'b0, "sel_lane0_off");
        do_xfer(1'b0, 3'd3, 8'h00, 4'b1110, 1'b0, "sel_read_unchanged");
        do_xfer(1'b1, 3'd3, 8'h55, 4'b0001, 1'b0, "sel_lane0_on");
        do_xfer(1'b0, 3'd3, 8'h00, 4'b0000, 1'b0, "sel_read_55");
`else
        do_xfer(1'b1, 3'd6, 8'h55, 4'b0000, 1'b0, "write_any_sel");
`endif
    endtask

    task automatic test_abort();
        do_xfer(1'b1, 3'd1, 8'hc3, 4'b0001, 1'b1, "abort_write");
        do_xfer(1'b0, 3'd1, 8'h00, 4'b0000, 1'b1, "abort_read");
        do_xfer(1'b0, 3'd1, 8'h00, 4'b0000, 1'b0, "after_abort");
    endtask

    task automatic test_reset_mid();
        logic [2:0] idx;
        idx = 3'($urandom);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = mk_adr(idx); dat_i = mk_dat(~model_rf[idx]); sel = 4'b0001;
        @(posedge clk); #1;
        tests_run++;
        if (we_o !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_strobe: got %b need 1", we_o); end
        wb_rst_ni = 1'b0;
        #1;
        model_dato = '0;
        tests_run++;
        if ({ack, re_o, we_o, adr_o, dat8_o} !== 14'd0 || dat_o !== '0) begin
            tests_failed++;
            $display("FAIL rst_mid_clear: got ack=%b re=%b we=%b adr=%0d d8=%02h dat_o=%0h need all 0",
                     ack, re_o, we_o, adr_o, dat8_o, dat_o);
        end
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk);
        @(negedge clk);
        wb_rst_ni = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            tests_run++;
            if ({ack, re_o, we_o} !== 3'b000) begin tests_failed++; $display("FAIL rst_residual: got %b need 000", {ack, re_o, we_o}); end
        end
        do_xfer(1'b0, idx, 8'h00, 4'b0000, 1'b0, "read_after_rst");
    endtask

    task automatic test_back_to_back();
        logic [2:0] cur;
        logic [2:0] cap;
        int acks;
        acks = 0;
        cap = 3'd0;
        cur = 3'($urandom);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = mk_adr(cur); dat_i = mk_dat(8'h00);
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            if (k % 3 == 1) cap = cur;
            if (ack === 1'b1) acks++;
            tests_run += 2;
            if (re_o !== (k % 3 == 1)) begin tests_failed++; $display("FAIL b2b_re cyc%0d: got %b need %b", k, re_o, (k % 3 == 1)); end
            if (ack !== (k % 3 == 2)) begin tests_failed++; $display("FAIL b2b_ack cyc%0d: got %b need %b", k, ack, (k % 3 == 2)); end
            if (k % 3 == 1) begin
                tests_run++;
                if (adr_o !== cap) begin tests_failed++; $display("FAIL b2b_adr cyc%0d: got %0d need %0d", k, adr_o, cap); end
            end
            if (k % 3 == 2) begin
                model_dato = DW'(model_rf[cap]);
                tests_run++;
                if (dat_o !== model_dato) begin tests_failed++; $display("FAIL b2b_dat cyc%0d: got %0h need %0h", k, dat_o, model_dato); end
            end
            cur = 3'($urandom);
            adr = mk_adr(cur);
        end
        cyc = 1'b0; stb = 1'b0;
        tests_run++;
        if (acks != 3) begin tests_failed++; $display("FAIL b2b_ack_count: got %0d need 3", acks); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            do_xfer(1'($urandom), 3'($urandom), 8'($urandom), 4'($urandom),
                    ($urandom_range(7, 0) == 0), "random");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_sel_lane();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
